// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand sequencer: opcodes,
// flag bit positions and the sequencer state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB = 2'd0,
    OP_ADD = 2'd1,
    OP_OR  = 2'd2,
    OP_AND = 2'd3
  } alu_op_t;

  // Flag vector layout {N,Z,C,V,P}
  localparam int FLAG_W = 5;
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

  // Encodings are visible on state_o, so they are pinned explicitly
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;

endpackage : alu_pkg

// File: rtl/alu_operand_sequencer_rise_detect.sv
// Rising-edge detector for an already-synchronised level input.
// One history flop plus an AND; reusable for any board button.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic r_in_d;

  // Remember last cycle's level so a held input produces one pulse only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_in_d <= 1'b0;
    end else begin
      r_in_d <= in;
    end
  end

  // A level that is high now but was low last cycle is a new press
  assign pulse = in & ~r_in_d;

endmodule : rise_detect

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer in front of a combinational ALU. Collects A, B and the
// opcode from one shared bus (one load press each), runs the ALU for one
// cycle, then latches and holds the result and flags for display.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int M = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [M-1:0]      data_in,
  input  logic              load,
  output logic [M-1:0]      alu_a,
  output logic [M-1:0]      alu_b,
  output logic [1:0]        alu_opcode,
  input  logic [M-1:0]      alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [M-1:0]      result_q,
  output logic [FLAG_W-1:0] flags_q,
  output logic              result_valid,
  output logic [2:0]        state_o
);

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic [M-1:0]      r_a;
  logic [M-1:0]      r_b;
  alu_op_t           r_op;
  logic [M-1:0]      r_result;
  logic [FLAG_W-1:0] r_flags;
  logic              r_valid;
  logic              w_load_edge;

  // A load held across reset release fires once on the first cycle, since
  // the detector history comes out of reset low; that press is honoured.
  rise_detect u_load_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (load),
    .pulse   (w_load_edge)
  );

  // Next-state: each WAIT step advances on a press, EXEC always lasts one
  // cycle, SHOW returns to WAIT_A on a press
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // w_state_next unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      WAIT_A:  if (w_load_edge) w_state_next = WAIT_B;
      WAIT_B:  if (w_load_edge) w_state_next = WAIT_OP;
      WAIT_OP: if (w_load_edge) w_state_next = EXEC;
      EXEC:    w_state_next = SHOW;
      SHOW:    if (w_load_edge) w_state_next = WAIT_A;
      default: w_state_next = WAIT_A;
    endcase
  end

  // State register plus operand/result capture; data_in is only looked at
  // on a press, and a press in EXEC is ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= WAIT_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_SUB;
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        WAIT_A: if (w_load_edge) begin
          r_a     <= data_in;
          r_valid <= 1'b0;
        end
        WAIT_B:  if (w_load_edge) r_b <= data_in;
        WAIT_OP: if (w_load_edge) r_op <= alu_op_t'(data_in[1:0]);
        EXEC: begin
          // ALU inputs settled one cycle ago; sample its combinational output
          r_result <= alu_result;
          r_flags  <= alu_flags;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_opcode   = r_op;
  assign result_q     = r_result;
  assign flags_q      = r_flags;
  assign result_valid = r_valid;
  assign state_o      = r_state;

endmodule : alu_operand_sequencer
